// File: rtl/des_pkg.sv
// des_pkg
// Shared definitions for the DES command sequencer: wrapper command codes,
// region index width and the sweeper state encoding, plus two small helpers
// that map a sweeper state onto the wrapper command it issues.
package des_pkg;

    localparam int REGION_W = 16;

    localparam logic [31:0] CMD_READ_REGION = 32'd0;
    localparam logic [31:0] CMD_START       = 32'd1;
    localparam logic [31:0] CMD_TEST_MODE   = 32'd2;
    localparam logic [31:0] CMD_RESTART     = 32'd3;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_START   = 4'd2,
        ST_WAIT    = 4'd3,
        ST_CAPTURE = 4'd4,
        ST_EMIT    = 4'd5,
        ST_RESTART = 4'd6,
        ST_NEXT    = 4'd7,
        ST_FINISH  = 4'd8
    } sweep_state_t;

    // States that own a command handshake with the wrapper.
    function automatic logic is_cmd_state(sweep_state_t s);
        return (s == ST_LOAD) || (s == ST_START) || (s == ST_RESTART);
    endfunction

    function automatic logic [31:0] cmd_of_state(sweep_state_t s);
        case (s)
            ST_START:   return CMD_START;
            ST_RESTART: return CMD_RESTART;
            default:    return CMD_READ_REGION;
        endcase
    endfunction

endpackage

// File: rtl/des_region_sweeper.sv
// des_region_sweeper
// Walks a range of regions through the DES wrapper: for each region it loads
// the region, starts the wrapper, waits for done, captures the 64-bit counter,
// hands it out on a valid/ready result port and restarts the wrapper.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   go                        start pulse, sampled only in IDLE
//   region_first/region_last  inclusive sweep range, sampled on go
//   abort                     request to end the sweep early
//   busy                      sweep in progress
//   sweep_done, aborted       end-of-sweep pulse and its abort qualifier
//   cmd, cmd_valid, region    registered command port to the wrapper
//   cmd_read                  wrapper acknowledge of the current command
//   done, counter             wrapper completion flag and counter result
//   res_valid, res_ready      result handshake
//   res_region, res_counter   captured result
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no sweep; waiting for go
// ST_LOAD    | read-region command outstanding
// ST_START   | start command (issued one cycle after entry)
// ST_WAIT    | wrapper running; waiting for done
// ST_CAPTURE | latch counter and region
// ST_EMIT    | result offered on res_valid
// ST_RESTART | restart command outstanding
// ST_NEXT    | advance to the next region
// ST_FINISH  | sweep_done pulse
module des_region_sweeper
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [REGION_W-1:0] region_first,
    input  logic [REGION_W-1:0] region_last,
    input  logic                abort,
    output logic                busy,
    output logic                sweep_done,
    output logic                aborted,
    output logic [31:0]         cmd,
    output logic                cmd_valid,
    output logic [31:0]         region,
    input  logic                cmd_read,
    input  logic                done,
    input  logic [63:0]         counter,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [REGION_W-1:0] res_region,
    output logic [63:0]         res_counter
);

    sweep_state_t        state_q, state_d;
    logic [REGION_W-1:0] cur_region_q, cur_region_d;
    logic [REGION_W-1:0] last_region_q;
    logic                abort_pend_q, abort_pend_d;
    logic [31:0]         cmd_d;
    logic                cmd_valid_d;
    logic                ack;
    logic                abort_now;
    logic                last_hit;

    assign ack       = cmd_valid && cmd_read;
    // An abort arriving this cycle acts immediately, not one cycle late.
    assign abort_now = abort_pend_q || abort;
    assign last_hit  = (cur_region_q == last_region_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (go) state_d = ST_LOAD;
            ST_LOAD:    if (ack) state_d = abort_now ? ST_FINISH : ST_START;
            // The wrapper ignores commands while running, so an abort here
            // still has to go through WAIT and a restart.
            ST_START:   if (ack) state_d = ST_WAIT;
            ST_WAIT:    if (done) state_d = abort_now ? ST_RESTART : ST_CAPTURE;
            ST_CAPTURE: state_d = ST_EMIT;
            ST_EMIT:    if ((res_valid && res_ready) || abort_now) state_d = ST_RESTART;
            ST_RESTART: if (ack) state_d = (last_hit || abort_now) ? ST_FINISH : ST_NEXT;
            ST_NEXT:    state_d = abort_now ? ST_FINISH : ST_LOAD;
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_region_d = cur_region_q;
        if ((state_q == ST_IDLE) && go) begin
            cur_region_d = region_first;
        end else if (state_q == ST_NEXT) begin
            cur_region_d = cur_region_q + REGION_W'(1);
        end

        // go and abort together in IDLE still start (and then abort) a sweep.
        abort_pend_d = abort_pend_q;
        if (state_d == ST_IDLE) begin
            abort_pend_d = 1'b0;
        end else if (abort) begin
            abort_pend_d = 1'b1;
        end

        // A command state keeps cmd_valid up until the acknowledge edge; a
        // command following an acknowledged one starts a cycle later, so the
        // wrapper always sees cmd_valid drop between commands.
        cmd_valid_d = is_cmd_state(state_d) && !ack;
        cmd_d       = is_cmd_state(state_d) ? cmd_of_state(state_d) : cmd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cur_region_q  <= '0;
            last_region_q <= '0;
            abort_pend_q  <= 1'b0;
            cmd           <= '0;
            cmd_valid     <= 1'b0;
            region        <= '0;
            res_region    <= '0;
            res_counter   <= '0;
        end else begin
            state_q      <= state_d;
            cur_region_q <= cur_region_d;
            abort_pend_q <= abort_pend_d;
            cmd          <= cmd_d;
            cmd_valid    <= cmd_valid_d;
            region       <= 32'(cur_region_d);
            if ((state_q == ST_IDLE) && go) begin
                last_region_q <= region_last;
            end
            // Latched even if done has already dropped; the sweep carries on.
            if (state_q == ST_CAPTURE) begin
                res_counter <= counter;
                res_region  <= cur_region_q;
            end
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign sweep_done = (state_q == ST_FINISH);
    assign aborted    = sweep_done && abort_pend_q;
    // A pending abort suppresses the offer; an abort input in the same cycle
    // as an accepted transfer still lets that transfer count.
    assign res_valid  = (state_q == ST_EMIT) && !abort_pend_q;

endmodule

// File: tb/tb_des_region_sweeper.sv
module tb_des_region_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [15:0] region_first = '0;
    logic [15:0] region_last = '0;
    logic        abort = 1'b0;
    logic        busy, sweep_done, aborted;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic [31:0] region;
    logic        cmd_read = 1'b0;
    logic        done = 1'b0;
    logic [63:0] counter = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_region;
    logic [63:0] res_counter;

    des_region_sweeper dut (
        .clk(clk), .rst(rst), .go(go),
        .region_first(region_first), .region_last(region_last),
        .abort(abort), .busy(busy), .sweep_done(sweep_done), .aborted(aborted),
        .cmd(cmd), .cmd_valid(cmd_valid), .region(region), .cmd_read(cmd_read),
        .done(done), .counter(counter),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_region(res_region), .res_counter(res_counter)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // wrapper model knobs
    int          run_len = 3;
    int          ack_max = 2;
    bit          block_ack = 1'b0;
    bit          rand_ready = 1'b0;
    bit          ready_val = 1'b1;
    logic [63:0] salt = 64'h0;

    // observation logs
    logic [31:0] hs_cmd[$];
    logic [31:0] hs_reg[$];
    logic [15:0] got_reg[$];
    logic [63:0] got_cnt[$];
    logic [15:0] exp_reg[$];
    int          n_done = 0;
    logic        last_aborted = 1'b0;
    int          bad_restart = 0;

    // wrapper model state
    bit          pend_ack = 1'b0;
    logic [31:0] ack_cmd, ack_reg;
    bit          running = 1'b0;
    int          run_left = 0;
    logic [15:0] wr_region = '0;
    int          ack_wait = 0;

    function automatic logic [63:0] cnt_of(logic [15:0] r);
        return {r, ~r, r ^ 16'h0F0F, 16'h5A5A} ^ salt;
    endfunction

    // Reference: every region from first to last inclusive, wrapping mod 2^16.
    task automatic build_expected(input logic [15:0] f, input logic [15:0] l);
        logic [15:0] span;
        exp_reg.delete();
        span = l - f;
        for (int i = 0; i <= int'(span); i++) exp_reg.push_back(f + 16'(i));
    endtask

    // Behavioural wrapper plus monitors. Everything here happens on the
    // falling edge, so values recorded are those the DUT sees at the next
    // rising edge.
    always @(negedge clk) begin
        if (rst) begin
            pend_ack  = 1'b0;
            running   = 1'b0;
            done      = 1'b0;
            cmd_read  = 1'b0;
            counter   = '0;
            ack_wait  = 0;
            res_ready = ready_val;
        end else begin
            if (pend_ack) begin
                pend_ack = 1'b0;
                if (ack_cmd == 32'd0) wr_region = ack_reg[15:0];
                else if (ack_cmd == 32'd1) begin
                    running  = 1'b1;
                    run_left = run_len;
                end else if (ack_cmd == 32'd3) done = 1'b0;
            end else if (running) begin
                if (run_left == 0) begin
                    running = 1'b0;
                    done    = 1'b1;
                    counter = 64'hBAD0_BAD0_BAD0_BAD0;  // not yet valid
                end else run_left--;
            end else if (done) begin
                counter = cnt_of(wr_region);
            end

            if (cmd_read) begin
                cmd_read = 1'b0;
                ack_wait = $urandom_range(0, ack_max);
            end else if (cmd_valid && !block_ack) begin
                if (ack_wait == 0) cmd_read = 1'b1;
                else ack_wait--;
            end
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;

            if (cmd_valid && cmd_read) begin
                pend_ack = 1'b1;
                ack_cmd  = cmd;
                ack_reg  = region;
                hs_cmd.push_back(cmd);
                hs_reg.push_back(region);
                if (cmd == 32'd3 && !done) bad_restart++;
            end
            if (res_valid && res_ready) begin
                got_reg.push_back(res_region);
                got_cnt.push_back(res_counter);
            end
            if (sweep_done) begin
                n_done++;
                last_aborted = aborted;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        hs_cmd.delete();
        hs_reg.delete();
        got_reg.delete();
        got_cnt.delete();
        bad_restart = 0;
    endtask

    task automatic start_sweep(input logic [15:0] f, input logic [15:0] l, input bit with_abort);
        region_first = f;
        region_last  = l;
        go           = 1'b1;
        abort        = with_abort;
        tick();
        go    = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_sweep(output bit ok);
        int start;
        start = n_done;
        for (int i = 0; i < 3000 && n_done == start; i++) tick();
        ok = (n_done != start);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, sweep_done, aborted, cmd_valid, res_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, sweep_done, aborted, cmd_valid, res_valid});
        end
        n_checks++;
        if ({cmd, region} !== 64'b0) begin
            n_fail++;
            $display("FAIL reset_cmd_region: got %h expected 0", {cmd, region});
        end
        n_checks++;
        if ({res_region, res_counter} !== 80'b0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 0", {res_region, res_counter});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int base_done;
        int exp_code;
        clear_logs();
        salt = {$urandom, $urandom};
        run_len = 3; ack_max = 2; rand_ready = 1'b0; ready_val = 1'b1;
        base_done = n_done;
        start_sweep(16'd5, 16'd7, 1'b0);
        n_checks++;
        if ({busy, cmd_valid, cmd, region} !== {1'b1, 1'b1, 32'd0, 32'd5}) begin
            n_fail++;
            $display("FAIL basic_load_entry: got busy=%b cv=%b cmd=%0d reg=%0d expected 1 1 0 5", busy, cmd_valid, cmd, region);
        end
        wait_sweep(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: sweep_done not seen"); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_finish: got %b expected 1", busy); end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
        build_expected(16'd5, 16'd7);
        n_checks++;
        if (got_reg.size() != exp_reg.size()) begin
            n_fail++;
            $display("FAIL basic_result_count: got %0d expected %0d", got_reg.size(), exp_reg.size());
        end
        for (int i = 0; i < exp_reg.size() && i < got_reg.size(); i++) begin
            n_checks++;
            if ({got_reg[i], got_cnt[i]} !== {exp_reg[i], cnt_of(exp_reg[i])}) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got %h/%h expected %h/%h", i, got_reg[i], got_cnt[i], exp_reg[i], cnt_of(exp_reg[i]));
            end
        end
        n_checks++;
        if (hs_cmd.size() != 9) begin n_fail++; $display("FAIL basic_ack_count: got %0d expected 9", hs_cmd.size()); end
        for (int i = 0; i < 9 && i < hs_cmd.size(); i++) begin
            exp_code = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 1 : 3;
            n_checks++;
            if ({hs_cmd[i], hs_reg[i]} !== {32'(exp_code), 32'(5 + i / 3)}) begin
                n_fail++;
                $display("FAIL basic_cmd[%0d]: got %0d/%0d expected %0d/%0d", i, hs_cmd[i], hs_reg[i], exp_code, 5 + i / 3);
            end
        end
        n_checks++;
        if ({n_done - base_done, last_aborted, bad_restart} !== {32'd1, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL basic_done: got sweeps=%0d aborted=%b bad_restart=%0d expected 1 0 0", n_done - base_done, last_aborted, bad_restart);
        end
    endtask

    task automatic test_sweep_rand(input string name, input logic [15:0] f, input logic [15:0] l);
        bit ok;
        clear_logs();
        salt = {$urandom, $urandom};
        rand_ready = 1'b1;
        start_sweep(f, l, 1'b0);
        wait_sweep(ok);
        tick();
        build_expected(f, l);
        n_checks++;
        if (!ok || got_reg.size() != exp_reg.size() || last_aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_count: got done=%b results=%0d aborted=%b expected 1 %0d 0", name, ok, got_reg.size(), last_aborted, exp_reg.size());
        end
        for (int i = 0; i < exp_reg.size() && i < got_reg.size(); i++) begin
            n_checks++;
            if ({got_reg[i], got_cnt[i]} !== {exp_reg[i], cnt_of(exp_reg[i])}) begin
                n_fail++;
                $display("FAIL %s_result[%0d]: got %h/%h expected %h/%h", name, i, got_reg[i], got_cnt[i], exp_reg[i], cnt_of(exp_reg[i]));
            end
        end
        n_checks++;
        if (hs_cmd.size() != 3 * exp_reg.size() || bad_restart != 0) begin
            n_fail++;
            $display("FAIL %s_acks: got %0d bad_restart=%0d expected %0d 0", name, hs_cmd.size(), bad_restart, 3 * exp_reg.size());
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_wrap();
        run_len = 2; ack_max = 1;
        test_sweep_rand("wrap", 16'hFFFE, 16'h0001);
    endtask

    task automatic test_random();
        logic [15:0] f;
        for (int s = 0; s < 6; s++) begin
            f       = 16'($urandom);
            run_len = $urandom_range(0, 6);
            ack_max = $urandom_range(0, 3);
            test_sweep_rand("random", f, f + 16'($urandom_range(0, 4)));
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int hs_n;
        logic [15:0] hold_reg;
        logic [63:0] hold_cnt;
        clear_logs();
        salt = {$urandom, $urandom};
        run_len = 4; ack_max = 1; rand_ready = 1'b0; ready_val = 1'b0;
        start_sweep(16'h0003, 16'h0003, 1'b0);
        for (int i = 0; i < 500 && !res_valid; i++) tick();
        n_checks++;
        if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout: got %b expected 1", res_valid); end
        hold_reg = res_region;
        hold_cnt = res_counter;
        hs_n     = hs_cmd.size();
        n_checks++;
        if ({hold_reg, hold_cnt} !== {16'h0003, cnt_of(16'h0003)}) begin
            n_fail++;
            $display("FAIL bp_data: got %h/%h expected 0003/%h", hold_reg, hold_cnt, cnt_of(16'h0003));
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if ({res_valid, res_region, res_counter, cmd_valid, 32'(hs_cmd.size())} !==
                {1'b1, hold_reg, hold_cnt, 1'b0, 32'(hs_n)}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b %h/%h cv=%b acks=%0d expected 1 %h/%h 0 %0d",
                         c, res_valid, res_region, res_counter, cmd_valid, hs_cmd.size(), hold_reg, hold_cnt, hs_n);
            end
        end
        ready_val = 1'b1;
        wait_sweep(ok);
        tick();
        n_checks++;
        if (!ok || got_reg.size() != 1 || hs_cmd.size() != 3 || last_aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: got done=%b results=%0d acks=%0d aborted=%b expected 1 1 3 0", ok, got_reg.size(), hs_cmd.size(), last_aborted);
        end
    endtask

    task automatic test_abort_wait();
        bit ok;
        clear_logs();
        run_len = 50; ack_max = 1; rand_ready = 1'b0; ready_val = 1'b1;
        start_sweep(16'd10, 16'd12, 1'b0);
        for (int i = 0; i < 200 && hs_cmd.size() < 2; i++) tick();
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_sweep(ok);
        tick();
        n_checks++;
        if (!ok || last_aborted !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_wait_done: got done=%b aborted=%b expected 1 1", ok, last_aborted);
        end
        n_checks++;
        if (got_reg.size() != 0) begin n_fail++; $display("FAIL abort_wait_results: got %0d expected 0", got_reg.size()); end
        n_checks++;
        if (hs_cmd.size() != 3 || hs_cmd[0] !== 32'd0 || hs_cmd[1] !== 32'd1 || hs_cmd[2] !== 32'd3 || bad_restart != 0) begin
            n_fail++;
            $display("FAIL abort_wait_cmds: got %0d acks bad_restart=%0d expected 0,1,3 after done", hs_cmd.size(), bad_restart);
        end
    endtask

    task automatic test_go_abort();
        bit ok;
        clear_logs();
        run_len = 3; ack_max = 2; ready_val = 1'b1;
        start_sweep(16'd40, 16'd45, 1'b1);
        wait_sweep(ok);
        tick();
        n_checks++;
        if (!ok || last_aborted !== 1'b1 || got_reg.size() != 0) begin
            n_fail++;
            $display("FAIL go_abort_done: got done=%b aborted=%b results=%0d expected 1 1 0", ok, last_aborted, got_reg.size());
        end
        n_checks++;
        if (hs_cmd.size() != 1 || hs_cmd[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL go_abort_cmds: got %0d acks expected a single read-region", hs_cmd.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        block_ack = 1'b1;
        start_sweep(16'd20, 16'd21, 1'b0);
        tick();
        n_checks++;
        if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_load: got cv=%b expected 1", cmd_valid); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, sweep_done, aborted, cmd_valid, res_valid, cmd, region, res_region, res_counter} !== 149'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got busy=%b cv=%b cmd=%h reg=%h expected all 0", busy, cmd_valid, cmd, region);
        end
        tick();
        rst = 1'b0;
        block_ack = 1'b0;
        tick();
        run_len = 2; ack_max = 1;
        test_sweep_rand("rst_clean", 16'd20, 16'd21);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_random();
        test_backpressure();
        test_abort_wait();
        test_go_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
